// File: rtl/sort_ascending_pipe_pkg.sv
// Shared definitions for the pipelined odd-even transposition sorter:
// legal size limits, slot roles within a stage and the median tap index.
package sort_ascending_pipe_pkg;

   localparam int MIN_INPUTS = 2;
   localparam int MAX_INPUTS = 81;

   // Role a slot plays in one stage of the network.
   typedef enum logic [1:0] {
      SLOT_PASS,
      SLOT_LO,
      SLOT_HI
   } slot_role_e;

   // Even stages pair (0,1),(2,3)...; odd stages pair (1,2),(3,4)...
   function automatic int pair_base(input int stage);
      return stage % 2;
   endfunction

   function automatic bit is_pair_lo(input int stage, input int k, input int n);
      return (k >= pair_base(stage)) && (((k - pair_base(stage)) % 2) == 0) && (k + 1 < n);
   endfunction

   function automatic slot_role_e slot_role(input int stage, input int k, input int n);
      if (is_pair_lo(stage, k, n)) begin
         return SLOT_LO;
      end
      if ((k > 0) && is_pair_lo(stage, k - 1, n)) begin
         return SLOT_HI;
      end
      return SLOT_PASS;
   endfunction

   // Lower median for even window sizes.
   function automatic int median_index(input int n);
      return (n - 1) / 2;
   endfunction

endpackage

// File: rtl/sort_ascending_pipe_if.sv
// Window-in / sorted-window-out bus of the median-filter sorter.
interface sort_ascending_pipe_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_INPUTS = 9,
   parameter int TAG_WIDTH  = 1
);

   // Handshake: a window moves across a side on a rising clk edge where its
   // valid and ready are both 1. Valid never waits on ready, and i_ready
   // depends only on o_valid/o_ready, never on i_valid.
   logic                             i_valid;
   logic                             i_ready;
   logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data;
   logic [TAG_WIDTH-1:0]             i_tag;
   logic                             o_valid;
   logic                             o_ready;
   logic [NUM_INPUTS*DATA_WIDTH-1:0] o_data;
   logic [TAG_WIDTH-1:0]             o_tag;
   logic [DATA_WIDTH-1:0]            o_min;
   logic [DATA_WIDTH-1:0]            o_mid;
   logic [DATA_WIDTH-1:0]            o_max;

   modport master (
      output i_valid, i_data, i_tag, o_ready,
      input  i_ready, o_valid, o_data, o_tag, o_min, o_mid, o_max
   );

   modport slave (
      input  i_valid, i_data, i_tag, o_ready,
      output i_ready, o_valid, o_data, o_tag, o_min, o_mid, o_max
   );

endinterface

// File: rtl/sort_ascending_pipe_cas.sv
// Combinational compare-and-swap cell; lo receives the value belonging in the
// lower slot, and equal samples are never swapped.
module sort_ascending_pipe_cas #(
   parameter int DATA_WIDTH = 8,
   parameter int DESCENDING = 0
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] lo,
   output logic [DATA_WIDTH-1:0] hi
);

   logic swap;

   always_comb begin
      swap = (DESCENDING != 0) ? (a < b) : (a > b);
      lo   = swap ? b : a;
      hi   = swap ? a : b;
   end

endmodule

// File: rtl/sort_ascending_pipe.sv
// Pipelined NUM_INPUTS-stage odd-even transposition sorter with a tag sideband,
// one window per clock, and a global stall when the output is blocked.
module sort_ascending_pipe
   import sort_ascending_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_INPUTS = 9,
   parameter int TAG_WIDTH  = 1,
   parameter int DESCENDING = 0
) (
   input logic                  clk,
   input logic                  rst,
   sort_ascending_pipe_if.slave bus
);

   localparam int LAST = NUM_INPUTS - 1;
   localparam int MID  = median_index(NUM_INPUTS);

   if ((NUM_INPUTS < MIN_INPUTS) || (NUM_INPUTS > MAX_INPUTS)) begin : g_bad_num_inputs
      $fatal(1, "sort_ascending_pipe: NUM_INPUTS=%0d outside 2..81", NUM_INPUTS);
   end
   if (TAG_WIDTH < 1) begin : g_bad_tag_width
      $fatal(1, "sort_ascending_pipe: TAG_WIDTH must be at least 1");
   end

   logic [DATA_WIDTH-1:0] src    [NUM_INPUTS][NUM_INPUTS];
   logic [DATA_WIDTH-1:0] nxt    [NUM_INPUTS][NUM_INPUTS];
   logic [DATA_WIDTH-1:0] data_q [NUM_INPUTS][NUM_INPUTS];
   logic [TAG_WIDTH-1:0]  tag_q  [NUM_INPUTS];
   logic [NUM_INPUTS-1:0] valid_q;
   logic                  stall;

   assign stall       = valid_q[LAST] & ~bus.o_ready;
   assign bus.i_ready = ~stall;

   // Stage s sorts pairs of the previous stage's register (the input bus for s=0).
   for (genvar s = 0; s < NUM_INPUTS; s++) begin : g_stage
      for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_src
         if (s == 0) begin : g_in
            assign src[s][k] = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
         end else begin : g_prev
            assign src[s][k] = data_q[s-1][k];
         end
      end

      for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_slot
         if (slot_role(s, k, NUM_INPUTS) == SLOT_LO) begin : g_cas
            sort_ascending_pipe_cas #(
               .DATA_WIDTH (DATA_WIDTH),
               .DESCENDING (DESCENDING)
            ) u_cas (
               .a  (src[s][k]),
               .b  (src[s][k+1]),
               .lo (nxt[s][k]),
               .hi (nxt[s][k+1])
            );
         end else if (slot_role(s, k, NUM_INPUTS) == SLOT_PASS) begin : g_pass
            assign nxt[s][k] = src[s][k];
         end
      end
   end

   // Bubbles advance their valid bit but leave the data/tag registers untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int s = 0; s < NUM_INPUTS; s++) begin
            tag_q[s] <= '0;
            for (int k = 0; k < NUM_INPUTS; k++) begin
               data_q[s][k] <= '0;
            end
         end
      end else if (!stall) begin
         valid_q <= {valid_q[LAST-1:0], bus.i_valid};
         if (bus.i_valid) begin
            data_q[0] <= nxt[0];
            tag_q[0]  <= bus.i_tag;
         end
         for (int s = 1; s < NUM_INPUTS; s++) begin
            if (valid_q[s-1]) begin
               data_q[s] <= nxt[s];
               tag_q[s]  <= tag_q[s-1];
            end
         end
      end
   end

   for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_out
      assign bus.o_data[k*DATA_WIDTH +: DATA_WIDTH] = data_q[LAST][k];
   end

   assign bus.o_valid = valid_q[LAST];
   assign bus.o_tag   = tag_q[LAST];
   assign bus.o_min   = data_q[LAST][0];
   assign bus.o_mid   = data_q[LAST][MID];
   assign bus.o_max   = data_q[LAST][LAST];

endmodule

// File: tb/tb_sort_ascending_pipe.sv
// Bench for sort_ascending_pipe: default 9x8 ascending, 9x8 descending and 25x10 instances.
module tb_sort_ascending_pipe;
   import sort_ascending_pipe_pkg::*;

   typedef struct packed {
      logic        chk;
      logic [31:0] cyc;
      logic [3:0]  tag;
      logic [71:0] data;
   } ent_t;

   typedef struct packed {
      logic [31:0]  cyc;
      logic [249:0] data;
   } big_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;

   ent_t m_q[$];
   ent_t d_q[$];
   big_t b_q[$];
   ent_t m_e;
   ent_t d_e;
   big_t b_e;

   logic ready_hold;
   logic rand_ready;
   logic rnd_ok = 1'b1;

   int win_a[9]  = '{10, 55, 23, 18, 92, 44, 67, 31, 76};
   int exp_a[9]  = '{10, 18, 23, 31, 44, 55, 67, 76, 92};
   int win_b[9]  = '{90, 10, 70, 50, 30, 80, 20, 60, 40};
   int exp_b[9]  = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
   int win_t[9]  = '{7, 7, 0, 255, 7, 0, 255, 7, 7};
   int exp_t[9]  = '{0, 0, 7, 7, 7, 7, 7, 255, 255};
   int exp_td[9] = '{255, 255, 7, 7, 7, 7, 7, 0, 0};

   sort_ascending_pipe_if #(.DATA_WIDTH(8),  .NUM_INPUTS(9),  .TAG_WIDTH(4)) m_bus ();
   sort_ascending_pipe_if #(.DATA_WIDTH(8),  .NUM_INPUTS(9),  .TAG_WIDTH(1)) d_bus ();
   sort_ascending_pipe_if #(.DATA_WIDTH(10), .NUM_INPUTS(25), .TAG_WIDTH(1)) b_bus ();

   sort_ascending_pipe #(.DATA_WIDTH(8), .NUM_INPUTS(9), .TAG_WIDTH(4), .DESCENDING(0)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (m_bus)
   );

   sort_ascending_pipe #(.DATA_WIDTH(8), .NUM_INPUTS(9), .TAG_WIDTH(1), .DESCENDING(1)) u_desc (
      .clk (clk),
      .rst (rst),
      .bus (d_bus)
   );

   sort_ascending_pipe #(.DATA_WIDTH(10), .NUM_INPUTS(25), .TAG_WIDTH(1), .DESCENDING(0)) u_big (
      .clk (clk),
      .rst (rst),
      .bus (b_bus)
   );

   assign m_bus.o_ready = ready_hold & (rnd_ok | ~rand_ready);
   assign d_bus.o_ready = 1'b1;
   assign b_bus.o_ready = 1'b1;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      rnd_ok = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string name, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic logic [71:0] pack9(input int v[9]);
      logic [71:0] r;
      r = '0;
      for (int k = 0; k < 9; k++) r[k*8 +: 8] = 8'(v[k]);
      return r;
   endfunction

   function automatic logic [71:0] model_sort9(input logic [71:0] w, input bit desc);
      int v[9];
      int t;
      int j;
      for (int k = 0; k < 9; k++) v[k] = int'(w[k*8 +: 8]);
      for (int i = 1; i < 9; i++) begin
         t = v[i];
         j = i - 1;
         while (j >= 0) begin
            if (desc ? (v[j] < t) : (v[j] > t)) begin
               v[j+1] = v[j];
               j--;
            end else begin
               break;
            end
         end
         v[j+1] = t;
      end
      return pack9(v);
   endfunction

   // ---------------- scoreboards ----------------
   always @(negedge clk) begin
      if (!rst && m_bus.o_valid && m_bus.o_ready) begin
         if (m_q.size() == 0) begin
            check_eq("m_unexpected_out", 1, 0);
         end else begin
            m_e = m_q.pop_front();
            check_eq("m_data", m_bus.o_data, m_e.data);
            check_eq("m_tag",  m_bus.o_tag,  m_e.tag);
            check_eq("m_min",  m_bus.o_min,  m_e.data[7:0]);
            check_eq("m_mid",  m_bus.o_mid,  m_e.data[39:32]);
            check_eq("m_max",  m_bus.o_max,  m_e.data[71:64]);
            if (m_e.chk) check_eq("m_latency", 32'(cyc) - m_e.cyc, 9);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && d_bus.o_valid && d_bus.o_ready) begin
         if (d_q.size() == 0) begin
            check_eq("d_unexpected_out", 1, 0);
         end else begin
            d_e = d_q.pop_front();
            check_eq("d_data",    d_bus.o_data, d_e.data);
            check_eq("d_tag",     d_bus.o_tag,  d_e.tag[0]);
            check_eq("d_min",     d_bus.o_min,  d_e.data[7:0]);
            check_eq("d_mid",     d_bus.o_mid,  d_e.data[39:32]);
            check_eq("d_max",     d_bus.o_max,  d_e.data[71:64]);
            check_eq("d_latency", 32'(cyc) - d_e.cyc, 9);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && b_bus.o_valid && b_bus.o_ready) begin
         if (b_q.size() == 0) begin
            check_eq("b_unexpected_out", 1, 0);
         end else begin
            b_e = b_q.pop_front();
            check_eq("b_data",    b_bus.o_data, b_e.data);
            check_eq("b_tag",     b_bus.o_tag,  1'b1);
            check_eq("b_min",     b_bus.o_min,  b_e.data[9:0]);
            check_eq("b_mid",     b_bus.o_mid,  b_e.data[129:120]);
            check_eq("b_max",     b_bus.o_max,  b_e.data[249:240]);
            check_eq("b_latency", 32'(cyc) - b_e.cyc, 25);
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic m_send(input logic [71:0] d, input logic [71:0] e, input logic [3:0] tg, input bit chk);
      int   guard;
      bit   acc;
      ent_t ent;
      m_bus.i_valid = 1'b1;
      m_bus.i_data  = d;
      m_bus.i_tag   = tg;
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 200) begin
         @(negedge clk);
         acc = m_bus.i_ready;
         if (acc) begin
            ent.chk  = chk;
            ent.cyc  = 32'(cyc);
            ent.tag  = tg;
            ent.data = e;
            m_q.push_back(ent);
         end
         @(posedge clk);
         #1;
         guard++;
      end
      if (!acc) check_eq("m_accept_timeout", 0, 1);
   endtask

   task automatic m_idle();
      m_bus.i_valid = 1'b0;
      m_bus.i_data  = {$urandom, $urandom, $urandom};
      m_bus.i_tag   = 4'($urandom_range(0, 15));
   endtask

   task automatic d_send(input logic [71:0] d, input logic [71:0] e, input logic tg);
      ent_t ent;
      d_bus.i_valid = 1'b1;
      d_bus.i_data  = d;
      d_bus.i_tag   = tg;
      @(negedge clk);
      check_eq("d_accept", d_bus.i_ready, 1);
      ent.chk  = 1'b1;
      ent.cyc  = 32'(cyc);
      ent.tag  = {3'b000, tg};
      ent.data = e;
      d_q.push_back(ent);
      @(posedge clk);
      #1;
      d_bus.i_valid = 1'b0;
   endtask

   task automatic b_send(input logic [249:0] d, input logic [249:0] e);
      big_t ent;
      b_bus.i_valid = 1'b1;
      b_bus.i_data  = d;
      b_bus.i_tag   = 1'b1;
      @(negedge clk);
      check_eq("b_accept", b_bus.i_ready, 1);
      ent.cyc  = 32'(cyc);
      ent.data = e;
      b_q.push_back(ent);
      @(posedge clk);
      #1;
      b_bus.i_valid = 1'b0;
   endtask

   task automatic drain(input int limit);
      int g;
      g = 0;
      while ((m_q.size() + d_q.size() + b_q.size()) != 0 && g < limit) begin
         @(posedge clk);
         g++;
      end
      #1;
      check_eq("drain_m", m_q.size(), 0);
      check_eq("drain_d", d_q.size(), 0);
      check_eq("drain_b", b_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [71:0]  rd;
      logic [249:0] bw;
      logic [249:0] be;
      int           g;

      cyc           = 0;
      checks        = 0;
      errors        = 0;
      ready_hold    = 1'b1;
      rand_ready    = 1'b0;
      m_bus.i_valid = 1'b0;
      m_bus.i_data  = '0;
      m_bus.i_tag   = '0;
      d_bus.i_valid = 1'b0;
      d_bus.i_data  = '0;
      d_bus.i_tag   = '0;
      b_bus.i_valid = 1'b0;
      b_bus.i_data  = '0;
      b_bus.i_tag   = '0;
      rst           = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_o_valid", m_bus.o_valid, 0);
      check_eq("rst_o_data",  m_bus.o_data,  0);
      check_eq("rst_o_tag",   m_bus.o_tag,   0);
      check_eq("rst_o_min",   m_bus.o_min,   0);
      check_eq("rst_o_mid",   m_bus.o_mid,   0);
      check_eq("rst_o_max",   m_bus.o_max,   0);
      check_eq("rst_i_ready", m_bus.i_ready, 1);
      check_eq("rst_b_valid", b_bus.o_valid, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // single window
      m_send(pack9(win_a), pack9(exp_a), 4'h5, 1'b1);
      m_idle();
      drain(40);

      // back-to-back windows
      m_send(pack9(win_a), pack9(exp_a), 4'h1, 1'b1);
      m_send(pack9(win_b), pack9(exp_b), 4'h2, 1'b1);
      m_idle();
      drain(40);

      // output stall with two windows in flight
      ready_hold = 1'b0;
      m_send(pack9(win_a), pack9(exp_a), 4'h3, 1'b0);
      m_send(pack9(win_b), pack9(exp_b), 4'h4, 1'b0);
      m_idle();
      g = 0;
      while (!m_bus.o_valid && g < 50) begin
         @(negedge clk);
         g++;
      end
      check_eq("stall_wait_valid", m_bus.o_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("stall_i_ready", m_bus.i_ready, 0);
         check_eq("stall_o_valid", m_bus.o_valid, 1);
         if (m_q.size() != 0) begin
            check_eq("stall_data", m_bus.o_data, m_q[0].data);
            check_eq("stall_tag",  m_bus.o_tag,  m_q[0].tag);
         end else begin
            check_eq("stall_queue", 0, 1);
         end
      end
      @(posedge clk);
      #1;
      ready_hold = 1'b1;
      drain(40);

      // ties, ascending and descending
      m_send(pack9(win_t), pack9(exp_t), 4'h6, 1'b1);
      m_idle();
      d_send(pack9(win_t), pack9(exp_td), 1'b1);
      d_send(pack9(win_a), model_sort9(pack9(win_a), 1'b1), 1'b0);
      drain(40);

      // 25 x 10-bit window, reversed and already sorted
      bw = '0;
      be = '0;
      for (int k = 0; k < 25; k++) begin
         bw[k*10 +: 10] = 10'(1000 - k);
         be[k*10 +: 10] = 10'(976 + k);
      end
      b_send(bw, be);
      b_send(be, be);
      drain(80);

      // random windows with random output back-pressure
      rand_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         for (int k = 0; k < 9; k++) begin
            rd[k*8 +: 8] = (i % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
         end
         m_send(rd, model_sort9(rd, 1'b0), 4'($urandom_range(0, 15)), 1'b0);
         if ($urandom_range(0, 3) == 0) begin
            m_idle();
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      m_idle();
      drain(300);
      rand_ready = 1'b0;
      @(posedge clk);
      #1;

      // reset with a window in flight
      m_send(pack9(win_b), pack9(exp_b), 4'h7, 1'b1);
      m_idle();
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_eq("mid_rst_o_valid", m_bus.o_valid, 0);
      check_eq("mid_rst_o_data",  m_bus.o_data,  0);
      check_eq("mid_rst_o_tag",   m_bus.o_tag,   0);
      check_eq("mid_rst_o_min",   m_bus.o_min,   0);
      check_eq("mid_rst_o_mid",   m_bus.o_mid,   0);
      check_eq("mid_rst_o_max",   m_bus.o_max,   0);
      check_eq("mid_rst_i_ready", m_bus.i_ready, 1);
      m_q.delete();
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      m_send(pack9(win_a), pack9(exp_a), 4'h8, 1'b1);
      m_idle();
      drain(40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
